// File: rtl/console_tx.sv
`default_nettype none
// ============================================================================
// Module   : console_tx
// Purpose  : Memory-mapped paced byte transmitter. Software writes bytes to
//            TXDATA and they are queued in a FIFO. A drain FSM sends them as a
//            valid/ready byte stream, leaving a programmable gap after each
//            byte. STATUS reports full/empty/level and a sticky overflow flag.
//            CTRL holds enable, irq_en and the gap divider.
// Ports    : clk_i, rst_i        - clock, asynchronous active-high reset
//            req_i/we_i/be_i/addr_i/wdata_i - bus request (granted same cycle)
//            rvalid_o/rdata_o/err_o         - bus response, one cycle later
//            tx_valid_o/tx_data_o/tx_ready_i - downstream byte stream
//            irq_o               - empty interrupt
// Config   : CONSOLE_TX_IRQ_EN - when defined, the registered empty
//            interrupt and the writable CTRL.irq_en bit are built. When it is
//            undefined, irq_o is tied low and CTRL bit1 reads as 0.
// Revision : 1.0 - initial release
// ============================================================================
module console_tx #(
    parameter int DEPTH   = 16,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        irq_o
);

    localparam int                 c_PTR_W      = $clog2(DEPTH);
    localparam logic [LEVEL_W-1:0] c_FULL_LEVEL = LEVEL_W'(DEPTH);
    localparam logic [LEVEL_W-1:0] c_LEVEL_ONE  = LEVEL_W'(1);
    localparam logic [9:0]         c_OFF_TXDATA = 10'h000;
    localparam logic [9:0]         c_OFF_STATUS = 10'h004;
    localparam logic [9:0]         c_OFF_CTRL   = 10'h008;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic               r_overflow;
    logic               r_enable;
    logic [7:0]         r_div;
    logic               r_irq_en;
    state_t             r_state;
    logic [7:0]         r_gap;
    logic               r_rvalid;
    logic [31:0]        r_rdata;
    logic               r_err;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [9:0]  w_off;
    logic        w_sel_txdata;
    logic        w_sel_status;
    logic        w_sel_ctrl;
    logic        w_legal;
    logic        w_ctrl_wr;
    logic        w_status_wr;
    logic        w_push_req;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_ovf_set;
    logic [31:0] w_status;
    logic [31:0] w_ctrl;
    logic [31:0] w_rdata_next;
    logic        w_err_next;
    logic        w_tx_valid;
    state_t      w_state_next;
    logic [7:0]  w_gap_next;

    // Offsets are word aligned, so comparing all ten bits also rejects
    // any access with addr_i[1:0] != 0.
    assign w_off        = addr_i[9:0];
    assign w_sel_txdata = (w_off == c_OFF_TXDATA);
    assign w_sel_status = (w_off == c_OFF_STATUS);
    assign w_sel_ctrl   = (w_off == c_OFF_CTRL);
    assign w_legal      = w_sel_txdata | w_sel_status | w_sel_ctrl;

    assign w_ctrl_wr    = req_i & we_i & w_sel_ctrl;
    assign w_status_wr  = req_i & we_i & w_sel_status;
    assign w_push_req   = req_i & we_i & w_sel_txdata & be_i[0];

    // Fullness is judged on the state at the start of the cycle, so a pop
    // in the same cycle never makes room for a push.
    assign w_full       = (r_level == c_FULL_LEVEL);
    assign w_empty      = (r_level == '0);
    assign w_push       = w_push_req & ~w_full;
    assign w_ovf_set    = w_push_req & w_full;
    assign w_pop        = (r_state == S_SEND) & tx_ready_i;

    // ------------------------------------------------------------------
    // Register read mux
    // ------------------------------------------------------------------
    always_comb begin
        w_status               = '0;
        w_status[0]            = w_full;
        w_status[1]            = w_empty;
        w_status[2]            = r_overflow;
        w_status[8 +: LEVEL_W] = r_level;
    end

    assign w_ctrl = {16'h0000, r_div, 6'b000000, r_irq_en, r_enable};

    always_comb begin
        w_rdata_next = '0;
        w_err_next   = req_i & ~w_legal;
        if (req_i && !we_i) begin
            if (w_sel_status) begin
                w_rdata_next = w_status;
            end else if (w_sel_ctrl) begin
                w_rdata_next = w_ctrl;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= req_i;
            r_rdata  <= w_rdata_next;
            r_err    <= w_err_next;
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;

    // ------------------------------------------------------------------
    // Control and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_enable   <= 1'b0;
            r_div      <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (w_ctrl_wr && be_i[0]) begin
                r_enable <= wdata_i[0];
            end
            if (w_ctrl_wr && be_i[1]) begin
                r_div <= wdata_i[15:8];
            end
            // A push and a STATUS write cannot share a cycle, so the set and
            // the clear never compete.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_status_wr && be_i[0] && wdata_i[2]) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef CONSOLE_TX_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr && be_i[0]) begin
                r_irq_en <= wdata_i[1];
            end
            r_irq <= r_irq_en & w_empty & (r_state == S_IDLE);
        end
    end

    assign irq_o = r_irq;
`else
    assign r_irq_en = 1'b0;
    assign irq_o    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata_i[7:0];
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LEVEL_ONE;
                2'b01:   r_level <= r_level - c_LEVEL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_gap   <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_gap   <= w_gap_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gap_next   = r_gap;
        w_tx_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Enable only gates the start of a byte; a byte already in
                // SEND is always completed.
                if (r_enable && !w_empty) begin
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                w_tx_valid = 1'b1;
                if (tx_ready_i) begin
                    w_gap_next   = r_div;
                    w_state_next = (r_div == 8'h00) ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                w_gap_next = r_gap - 8'h01;
                if (r_gap == 8'h01) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign tx_valid_o = w_tx_valid;
    assign tx_data_o  = (r_state == S_SEND) ? r_mem[r_rd_ptr] : 8'h00;

    // Bus bits that are not decoded.
    logic w_unused;
    assign w_unused = ^{addr_i[31:10], wdata_i[31:16], be_i[3:2]};

endmodule
`default_nettype wire
